// File: rtl/stack_renderer.sv
// stack_renderer
// Pixel renderer for the stack game. Generates VGA timing, snapshots the
// game state into shadow registers once per frame (at hc=0, vc=V_ACTIVE) so
// a frame never mixes old and new state, and draws up to DEPTH stacked
// layers plus one falling block through a fixed 2-stage pixel pipeline.
//
// Ports:
//   dclk        pixel clock
//   rst         synchronous reset, active-high
//   stack_clr   layer i colour at [2i+1:2i] (00 none, 01 green, 10 red, 11 blue)
//   stack_x     layer i left edge at [10i+9:10i]
//   stack_cnt   number of valid layers (saturates to DEPTH on load)
//   fall_x/y    falling block left/top edge
//   fall_clr    falling block colour, 00 hides it
//   scroll      downward view offset applied to the stack only
//   frame_start one-cycle pulse in the cycle the shadow registers load
//   HS/VS       active-low syncs, aligned with the RGB pins
//   RED/GREEN/BLUE  pixel colour, 2 dclk after the counter state
module stack_renderer #(
    parameter int DEPTH    = 16,
    parameter int LAYER_H  = 20,
    parameter int BLOCK_W  = 100,
    parameter int BASE_Y   = 400,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic                 dclk,
    input  logic                 rst,
    input  logic [2*DEPTH-1:0]   stack_clr,
    input  logic [10*DEPTH-1:0]  stack_x,
    input  logic [CW-1:0]        stack_cnt,
    input  logic [9:0]           fall_x,
    input  logic [9:0]           fall_y,
    input  logic [1:0]           fall_clr,
    input  logic [9:0]           scroll,
    output logic                 frame_start,
    output logic                 HS,
    output logic                 VS,
    output logic [2:0]           RED,
    output logic [2:0]           GREEN,
    output logic [1:0]           BLUE
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;

    localparam logic signed [11:0] BW_S = 12'(BLOCK_W);
    localparam logic signed [11:0] LH_S = 12'(LAYER_H);

    logic [9:0] hc_q, hc_d, vc_q, vc_d;

    logic [2*DEPTH-1:0]  sh_clr_q, sh_clr_d;
    logic [10*DEPTH-1:0] sh_x_q, sh_x_d;
    logic [CW-1:0]       sh_cnt_q, sh_cnt_d;
    logic [9:0]          sh_fx_q, sh_fx_d, sh_fy_q, sh_fy_d;
    logic [1:0]          sh_fclr_q, sh_fclr_d;
    logic [9:0]          sh_scroll_q, sh_scroll_d;

    logic [1:0] clr1_q, clr1_d;
    logic       act1_q, act1_d;
    logic       hs1_q, hs1_d, vs1_q, vs1_d;
    logic       hs2_q, hs2_d, vs2_q, vs2_d;
    logic [2:0] red_q, red_d, green_q, green_d;
    logic [1:0] blue_q, blue_d;

    logic                 load;
    logic [1:0]           pix_clr;
    logic signed [11:0]   hc_s, vc_s, layer_sx, layer_top;
    logic [10:0]          hc_u, vc_u, fall_xu, fall_yu;

    // Free-running raster position; the line counter steps on hc wrap.
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == 10'(H_TOTAL - 1)) begin
            hc_d = 10'd0;
            if (vc_q == 10'(V_TOTAL - 1)) begin
                vc_d = 10'd0;
            end else begin
                vc_d = vc_q + 10'd1;
            end
        end
    end

    // First blanked line start is the single point where new game state is
    // taken, so every visible frame renders from one consistent snapshot.
    assign load        = (hc_q == 10'd0) && (vc_q == 10'(V_ACTIVE));
    assign frame_start = load & ~rst;

    always_comb begin
        sh_clr_d    = sh_clr_q;
        sh_x_d      = sh_x_q;
        sh_cnt_d    = sh_cnt_q;
        sh_fx_d     = sh_fx_q;
        sh_fy_d     = sh_fy_q;
        sh_fclr_d   = sh_fclr_q;
        sh_scroll_d = sh_scroll_q;
        if (load) begin
            sh_clr_d    = stack_clr;
            sh_x_d      = stack_x;
            sh_cnt_d    = (stack_cnt > CW'(DEPTH)) ? CW'(DEPTH) : stack_cnt;
            sh_fx_d     = fall_x;
            sh_fy_d     = fall_y;
            sh_fclr_d   = fall_clr;
            sh_scroll_d = scroll;
        end
    end

    // Hit test. Layer bounds use 12-bit signed maths so a scrolled layer
    // whose edges leave the 0..1023 range is clipped instead of wrapping.
    // Ascending scan lets the highest layer index win; the falling block
    // is checked last so it overrides the stack.
    always_comb begin
        pix_clr   = 2'b00;
        hc_s      = {2'b00, hc_q};
        vc_s      = {2'b00, vc_q};
        layer_sx  = 12'sd0;
        layer_top = 12'sd0;
        hc_u      = {1'b0, hc_q};
        vc_u      = {1'b0, vc_q};
        fall_xu   = {1'b0, sh_fx_q};
        fall_yu   = {1'b0, sh_fy_q};
        for (int i = 0; i < DEPTH; i++) begin
            layer_sx  = {2'b00, sh_x_q[10*i +: 10]};
            layer_top = $signed(12'(BASE_Y)) + $signed({2'b00, sh_scroll_q})
                        - $signed(12'((i + 1) * LAYER_H));
            if ((CW'(i) < sh_cnt_q) && (sh_clr_q[2*i +: 2] != 2'b00) &&
                (layer_sx < hc_s) && (hc_s < layer_sx + BW_S) &&
                (layer_top < vc_s) && (vc_s < layer_top + LH_S)) begin
                pix_clr = sh_clr_q[2*i +: 2];
            end
        end
        if ((sh_fclr_q != 2'b00) &&
            (fall_xu < hc_u) && (hc_u < fall_xu + 11'(BLOCK_W)) &&
            (fall_yu < vc_u) && (vc_u < fall_yu + 11'(LAYER_H))) begin
            pix_clr = sh_fclr_q;
        end
    end

    // Stage 1: winning colour, active-video flag and raw syncs.
    always_comb begin
        clr1_d = pix_clr;
        act1_d = (hc_q < 10'(H_ACTIVE)) && (vc_q < 10'(V_ACTIVE));
        hs1_d  = !((hc_q >= 10'(HS_START)) && (hc_q <= 10'(HS_END)));
        vs1_d  = !((vc_q >= 10'(VS_START)) && (vc_q <= 10'(VS_END)));
    end

    // Stage 2: colour decode, blanked outside active video.
    always_comb begin
        red_d   = 3'd0;
        green_d = 3'd0;
        blue_d  = 2'd0;
        hs2_d   = hs1_q;
        vs2_d   = vs1_q;
        if (act1_q) begin
            case (clr1_q)
                2'b01:   green_d = 3'd7;
                2'b10:   red_d   = 3'd7;
                2'b11:   blue_d  = 2'd3;
                default: ;
            endcase
        end
    end

    always_ff @(posedge dclk) begin
        if (rst) begin
            hc_q        <= 10'd0;
            vc_q        <= 10'd0;
            sh_clr_q    <= '0;
            sh_x_q      <= '0;
            sh_cnt_q    <= '0;
            sh_fx_q     <= 10'd0;
            sh_fy_q     <= 10'd0;
            sh_fclr_q   <= 2'b00;
            sh_scroll_q <= 10'd0;
            clr1_q      <= 2'b00;
            act1_q      <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            hs2_q       <= 1'b1;
            vs2_q       <= 1'b1;
            red_q       <= 3'd0;
            green_q     <= 3'd0;
            blue_q      <= 2'd0;
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            sh_clr_q    <= sh_clr_d;
            sh_x_q      <= sh_x_d;
            sh_cnt_q    <= sh_cnt_d;
            sh_fx_q     <= sh_fx_d;
            sh_fy_q     <= sh_fy_d;
            sh_fclr_q   <= sh_fclr_d;
            sh_scroll_q <= sh_scroll_d;
            clr1_q      <= clr1_d;
            act1_q      <= act1_d;
            hs1_q       <= hs1_d;
            vs1_q       <= vs1_d;
            hs2_q       <= hs2_d;
            vs2_q       <= vs2_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
        end
    end

    assign HS    = hs2_q;
    assign VS    = vs2_q;
    assign RED   = red_q;
    assign GREEN = green_q;
    assign BLUE  = blue_q;

endmodule

// File: doc/stack_renderer.md
Name: stack_renderer

Overview:
Parametrised, pipelined successor to the stack-game pixel renderer. Generates its own VGA timing and latches the game state (per-layer colour, per-layer x offset, layer count, falling block, vertical scroll) once per frame into shadow registers, giving tear-free frames. Renders up to DEPTH stacked layers plus one falling block. Drives the VGA pins with a fixed 2-cycle pixel pipeline and sync outputs aligned to it.

Parameters:
DEPTH, 16, max stacked layers drawn
LAYER_H, 20, layer height in pixels
BLOCK_W, 100, block width in pixels
BASE_Y, 400, bottom edge of layer 0 at scroll 0
H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in dclk cycles
V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines
CW, $clog2(DEPTH+1), width of stack_cnt

Ports:
dclk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
stack_clr  in  2*DEPTH  colour of layer i at [2i+1:2i]; 00 none, 01 green, 10 red, 11 blue
stack_x  in  10*DEPTH  left edge of layer i at [10i+9:10i]
stack_cnt  in  CW  number of valid layers
fall_x  in  10  falling block left edge
fall_y  in  10  falling block top edge
fall_clr  in  2  falling block colour, same encoding; 00 hides it
scroll  in  10  downward view offset in pixels
frame_start  out  1  one-cycle pulse when shadow registers load
HS  out  1  horizontal sync, active-low
VS  out  1  vertical sync, active-low
RED  out  3  red
GREEN  out  3  green
BLUE  out  2  blue

Behaviour:
- Counters: hc 0..H_TOTAL-1 (800), vc 0..V_TOTAL-1 (525). hc wraps to 0 and vc increments; at vc=524,hc=799 both wrap to 0.
- Raw sync: hs_n=0 for hc in [656,751], vs_n=0 for vc in [490,491]. Active video: hc<640 and vc<480.
- Shadow load: on the cycle with hc=0 and vc=480, every input is copied to shadow registers. frame_start=1 in that same cycle only. Rendering uses shadow values only, so input changes mid-frame have no effect until the next load.
- stack_cnt > DEPTH loads as DEPTH.
- Layer i is drawn only when i < cnt and clr_i != 00.
- Layer i hit: sx_i < hc < sx_i+BLOCK_W and top_i < vc < top_i+LAYER_H, all comparisons strict. top_i = BASE_Y + scroll - (i+1)*LAYER_H.
- Bound arithmetic is 12-bit signed. Bounds going negative or beyond 1023 are compared exactly, with no wrap; off-screen parts are clipped naturally.
- Falling hit: fall_x < hc < fall_x+BLOCK_W and fall_y < vc < fall_y+LAYER_H, computed 11-bit unsigned. Scroll does not apply to the falling block.
- Priority: falling block over stack. Within the stack, the highest hit index wins. Layers are disjoint by strict bounds; the priority rule is a tie-break only.
- Colour map: 01 gives G=7; 10 gives R=7; 11 gives B=3; no hit gives 0,0,0.
- Pipeline stage 1 registers the winning 2-bit colour and the active flag. Stage 2 registers RGB, forced to 0 outside active video.
- HS and VS are delayed by 2 registers so they stay aligned with RGB. Latency from counter state to pin is exactly 2 dclk.
- Reset values: hc=vc=0, HS=1, VS=1, RGB=0, frame_start=0, all pipeline registers 0. Shadow registers reset to cnt=0 and fall_clr=00, so the screen is black until the first load.
- Reset mid-frame: the counters restart at 0 on the next cycle, and the pipeline flushes to black.

Test Plan:
1. Reset for 3 cycles, then release -> HS falls exactly 658 cycles after release (count 656 + 2 latency). One line is 800 cycles. VS is low for 1600 cycles starting at line 490.
2. Set layer 0 to clr 10, x 260; cnt=1; scroll=0; wait for frame_start -> RED=7 exactly for hc 261..359, vc 381..399. All other pixels are 0, including hc=260, hc=360, vc=380, vc=400.
3. Add layer 1 with clr 11, x 300; cnt=2; plus a falling block with clr 01 at (320,385) -> B=3 on vc 361..379. G=7 on hc 321..419, vc 386..404, overriding red inside the overlap.
4. Change stack_clr mid-frame at vc=200 -> the current frame is unchanged; the new colours appear only after the next frame_start (hc=0, vc=480).
5. Set cnt=31 (saturates to 16) with all 16 layers clr 01 and scroll=0 -> layer 15 has top_15 = 80, so G=7 appears on vc 81..99. Layers at index 16 and above never draw.
6. Set scroll=20 with layer 0 at x 260 -> layer 0 is drawn on vc 401..419. Then set scroll=100 with cnt=1 -> vc 481..499 is blanked, so no pixel is lit.
